// File: rtl/inert_resp_pkg.sv
// inert_resp_pkg: register addresses, frame states and defaults shared by spi_inert_resp
package inert_resp_pkg;
    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CFG10     = 7'h10;
    localparam logic [6:0] ADDR_CFG11     = 7'h11;
    localparam logic [6:0] ADDR_CFG14     = 7'h14;
    localparam logic [6:0] ADDR_STATUS    = 7'h1E;
    localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
    localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
    localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
    localparam logic [6:0] ADDR_AZ_H      = 7'h2D;
    localparam logic [7:0] WHO_AM_I_DEF   = 8'h6A;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} frame_state_t;
endpackage

// File: rtl/spi_slv16_shift.sv
// spi_slv16_shift: synchronised 16-bit SPI responder frame engine with same-frame read byte
module spi_slv16_shift
    import inert_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [7:0]  rd_data,
    output logic        MISO,
    output logic        ss_high,
    output logic [6:0]  rd_addr,
    output logic        addr_vld,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [15:0] frame
);
    logic [2:0] ss_sr, sclk_sr;
    logic [1:0] mosi_sr;
    logic [3:0] bit_cnt;
    logic [7:0] tx;
    frame_state_t state;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise, shifting;

    assign ss_high     = ss_sr[1];
    assign ss_fall     = ss_sr[2] & ~ss_sr[1];
    assign ss_rise     = ~ss_sr[2] & ss_sr[1];
    assign sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
    assign shifting    = sclk_rise && (state == CMD || state == DATA);
    // address is complete only with the bit arriving on the 8th rise
    assign rd_addr     = {frame[5:0], mosi_sr[1]};
    assign addr_vld    = shifting && state == CMD && bit_cnt == 4'd7;
    assign frame_done  = ss_rise && state == DONE;
    assign frame_abort = ss_rise && (state == CMD || state == DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sr   <= '1;
            sclk_sr <= '1;
            mosi_sr <= '0;
            state   <= IDLE;
            bit_cnt <= '0;
            frame   <= '0;
            tx      <= '0;
            MISO    <= 1'b0;
        end else begin
            ss_sr   <= {ss_sr[1:0], SS_n};
            sclk_sr <= {sclk_sr[1:0], SCLK};
            mosi_sr <= {mosi_sr[0], MOSI};
            if (ss_rise)
                state <= IDLE;
            else if (ss_fall) begin
                state   <= CMD;
                bit_cnt <= '0;
                frame   <= '0;
            end else if (shifting) begin
                frame   <= {frame[14:0], mosi_sr[1]};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7)
                    state <= DATA;
                if (bit_cnt == 4'd15)
                    state <= DONE;
            end
            if (addr_vld)
                tx <= rd_data;
            else if (sclk_fall && (state == DATA || state == DONE))
                tx <= {tx[6:0], 1'b0};
            MISO <= (ss_high || state == IDLE || state == CMD) ? 1'b0 : (sclk_fall ? tx[7] : MISO);
        end
    end
endmodule

// File: rtl/spi_inert_resp.sv
// spi_inert_resp: inertial-sensor SPI responder with register file, sample latch and INT
// Optional overrun status bit built when SPI_INERT_RESP_OVRN_EN is defined.
module spi_inert_resp
    import inert_resp_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = WHO_AM_I_DEF,
    parameter int         INT_CTRL_BIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl_vld,
    input  logic [15:0] ptch_in,
    input  logic [15:0] AZ_in,
    output logic        cfg_done
);
    logic [15:0] frame, ptch, az, shd_ptch, shd_az;
    logic [7:0]  int1_ctrl, cfg10, cfg11, cfg14, rd_mux, rd_data;
    logic [6:0]  rd_addr, fa;
    logic [3:0]  cfg_seen;
    logic ss_high, addr_vld, frame_done, frame_abort, frame_end;
    logic wr, rd_end, apply_now, apply, shd_vld, pending, ovrn;

    spi_slv16_shift u_shift (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .rd_data(rd_data), .MISO(MISO), .ss_high(ss_high), .rd_addr(rd_addr),
        .addr_vld(addr_vld), .frame_done(frame_done), .frame_abort(frame_abort), .frame(frame)
    );

    assign fa        = frame[14:8];
    assign frame_end = frame_done | frame_abort;
    assign wr        = frame_done & ~frame[15];
    assign rd_end    = frame_done & frame[15];
    assign apply_now = smpl_vld & ss_high;
    // a sample shadowed during a frame is applied on the SS_n rise; a direct sample is newer
    assign apply     = apply_now | (frame_end & shd_vld);
    assign INT       = pending & int1_ctrl[INT_CTRL_BIT];
    assign cfg_done  = &cfg_seen;
    assign rd_data   = addr_vld ? rd_mux : 8'h00;

    always_comb begin
        rd_mux = 8'h00;
        case (rd_addr)
            ADDR_INT1_CTRL: rd_mux = int1_ctrl;
            ADDR_WHO_AM_I:  rd_mux = WHO_AM_I_VAL;
            ADDR_CFG10:     rd_mux = cfg10;
            ADDR_CFG11:     rd_mux = cfg11;
            ADDR_CFG14:     rd_mux = cfg14;
            ADDR_STATUS:    rd_mux = {6'b0, ovrn, pending};
            ADDR_PTCH_L:    rd_mux = ptch[7:0];
            ADDR_PTCH_H:    rd_mux = ptch[15:8];
            ADDR_AZ_L:      rd_mux = az[7:0];
            ADDR_AZ_H:      rd_mux = az[15:8];
            default:        rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int1_ctrl <= '0;
            cfg10     <= '0;
            cfg11     <= '0;
            cfg14     <= '0;
            cfg_seen  <= '0;
            ptch      <= '0;
            az        <= '0;
            shd_ptch  <= '0;
            shd_az    <= '0;
            shd_vld   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (wr && fa == ADDR_INT1_CTRL) int1_ctrl <= frame[7:0];
            if (wr && fa == ADDR_CFG10) cfg10 <= frame[7:0];
            if (wr && fa == ADDR_CFG11) cfg11 <= frame[7:0];
            if (wr && fa == ADDR_CFG14) cfg14 <= frame[7:0];
            cfg_seen <= cfg_seen | ({4{wr}} & {fa == ADDR_CFG14, fa == ADDR_CFG11, fa == ADDR_CFG10, fa == ADDR_INT1_CTRL});
            if (smpl_vld && !ss_high) begin
                shd_ptch <= ptch_in;
                shd_az   <= AZ_in;
                shd_vld  <= 1'b1;
            end else if (frame_end)
                shd_vld <= 1'b0;
            if (apply) begin
                ptch <= apply_now ? ptch_in : shd_ptch;
                az   <= apply_now ? AZ_in : shd_az;
            end
            pending <= apply | (pending & ~(rd_end && fa == ADDR_AZ_H));
        end
    end

`ifdef SPI_INERT_RESP_OVRN_EN
    always_ff @(posedge clk)
        ovrn <= !rst_n ? 1'b0 : (apply & pending) | (ovrn & ~(rd_end && fa == ADDR_STATUS));
`else
    assign ovrn = 1'b0;
`endif
endmodule

// File: tb/tb_spi_inert_resp.sv
// tb_spi_inert_resp: directed plus randomized frames checked against a transaction-level register model
module tb_spi_inert_resp;
    logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0, smpl_vld = 1'b0;
    logic [15:0] ptch_in = '0, AZ_in = '0;
    logic MISO, INT, cfg_done;
    int n_chk = 0, n_pass = 0;

    logic [7:0] m_reg [128];
    logic m_pend = 1'b0, m_ovrn = 1'b0;
    logic [3:0] m_cfg = '0;

    always #5 clk = ~clk;

    spi_inert_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .INT(INT), .smpl_vld(smpl_vld), .ptch_in(ptch_in), .AZ_in(AZ_in), .cfg_done(cfg_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        logic ov;
`ifdef SPI_INERT_RESP_OVRN_EN
        ov = m_ovrn;
`else
        ov = 1'b0;
`endif
        if (a == 7'h0F) return 8'h6A;
        if (a == 7'h1E) return {6'b0, ov, m_pend};
        return m_reg[a];
    endfunction

    function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h0D: begin m_reg[a] = d; m_cfg[0] = 1'b1; end
            7'h10: begin m_reg[a] = d; m_cfg[1] = 1'b1; end
            7'h11: begin m_reg[a] = d; m_cfg[2] = 1'b1; end
            7'h14: begin m_reg[a] = d; m_cfg[3] = 1'b1; end
            default: ;
        endcase
    endfunction

    function automatic void m_sample(input logic [15:0] p, input logic [15:0] z);
        m_ovrn = m_ovrn | m_pend;
        m_pend = 1'b1;
        m_reg[7'h22] = p[7:0];
        m_reg[7'h23] = p[15:8];
        m_reg[7'h2C] = z[7:0];
        m_reg[7'h2D] = z[15:8];
    endfunction

    task automatic pulse_smpl(input logic [15:0] p, input logic [15:0] z);
        @(negedge clk);
        smpl_vld = 1'b1;
        ptch_in = p;
        AZ_in = z;
        @(negedge clk);
        smpl_vld = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int rises, input bit mid,
                             input logic [15:0] p, input logic [15:0] z, output logic [7:0] rdb);
        rdb = 8'h00;
        SS_n = 1'b0;
        #100;
        for (int i = 0; i < rises; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            #80;
            SCLK = 1'b1;
            if (i >= 8) rdb = {rdb[6:0], MISO};
            if (i == 4) check("miso_cmd", {31'b0, MISO}, 32'h0);
            if (mid && i == 10) pulse_smpl(p, z);
            #80;
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        #100;
    endtask

    task automatic check_side(input string tag);
        check({tag, "_int"}, {31'b0, INT}, {31'b0, m_pend & m_reg[7'h0D][1]});
        check({tag, "_cfg"}, {31'b0, cfg_done}, {31'b0, &m_cfg});
        check({tag, "_miso_idle"}, {31'b0, MISO}, 32'h0);
    endtask

    task automatic do_read(input logic [6:0] a, input int rises, input bit mid);
        logic [7:0] got, exp;
        logic [15:0] p, z;
        p = 16'($urandom);
        z = 16'($urandom);
        exp = m_read(a);
        spi_frame({1'b1, a, 8'($urandom)}, rises, mid, p, z, got);
        if (rises == 16) begin
            check($sformatf("rd_%02h", a), {24'b0, got}, {24'b0, exp});
            if (a == 7'h2D) m_pend = 1'b0;
            if (a == 7'h1E) m_ovrn = 1'b0;
        end
        if (mid) m_sample(p, z);
        check_side($sformatf("after_rd_%02h", a));
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int rises);
        logic [7:0] junk;
        spi_frame({1'b0, a, d}, rises, 1'b0, 16'h0, 16'h0, junk);
        if (rises == 16) m_write(a, d);
        check_side($sformatf("after_wr_%02h", a));
    endtask

    task automatic do_sample(input logic [15:0] p, input logic [15:0] z);
        pulse_smpl(p, z);
        m_sample(p, z);
        check("smpl_int", {31'b0, INT}, {31'b0, m_pend & m_reg[7'h0D][1]});
    endtask

    logic [6:0] rd_list [10] = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h1E, 7'h22, 7'h23, 7'h2C, 7'h2D};
    logic [6:0] wr_list [5] = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h0F};

    initial begin
        for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_miso", {31'b0, MISO}, 32'h0);
        check("rst_int", {31'b0, INT}, 32'h0);
        check("rst_cfg", {31'b0, cfg_done}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(7'h0F, 16, 1'b0);
        do_read(7'h0D, 16, 1'b0);
        do_write(7'h0D, 8'h02, 16);
        do_write(7'h10, 8'h53, 16);
        do_write(7'h11, 8'h50, 16);
        check("cfg_before_4th", {31'b0, cfg_done}, 32'h0);
        do_write(7'h14, 8'h60, 16);
        do_read(7'h0D, 16, 1'b0);
        do_sample(16'h1234, 16'hABCD);
        do_read(7'h22, 16, 1'b0);
        do_read(7'h23, 16, 1'b0);
        do_read(7'h2C, 16, 1'b0);
        do_read(7'h2D, 16, 1'b0);
        do_write(7'h0D, 8'h00, 10);
        do_read(7'h0D, 16, 1'b0);
        do_read(7'h22, 16, 1'b1);
        do_read(7'h22, 16, 1'b0);
        do_read(7'h2D, 12, 1'b0);
        do_read(7'h1E, 16, 1'b0);
`ifdef SPI_INERT_RESP_OVRN_EN
        do_sample(16'h1111, 16'h2222);
        do_read(7'h1E, 16, 1'b0);
        do_read(7'h1E, 16, 1'b0);
`endif
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0: do_sample(16'($urandom), 16'($urandom));
                1: do_write(wr_list[$urandom_range(0, 4)], 8'($urandom), 16);
                2: do_write(7'($urandom), 8'($urandom), $urandom_range(9, 16));
                3: do_read(7'($urandom), 16, 1'b0);
                4: do_read(rd_list[$urandom_range(0, 9)], $urandom_range(12, 16), 1'b0);
                default: do_read(rd_list[$urandom_range(0, 9)], 16, 1'($urandom));
            endcase
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
